mm_stream_acc: RTL and testbench

Streaming, tiled matrix-multiply engine that generalises the all-parallel register GEMM with a depth dimension. It computes C = A·B for A of ROW_NUM×(LENGTH·k_tiles) and B of (LENGTH·k_tiles)×COL_NUM. The K dimension arrives as a sequence of LENGTH-wide tile beats over a valid/ready handshake and is accumulated in wide registers. The result is scaled, saturated and presented on a held valid/ready output, so the block sits between operand buffers and a result FIFO in the GEMM datapath.

---
 rtl/mm_stream_acc.sv | 148 ++++++++++++++
 tb/tb_mm_stream_acc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mm_stream_acc.sv
// Streaming tiled GEMM: K-tile beats are multiplied, accumulated wide,
// then shifted, saturated and held on a valid/ready result port.
module mm_stream_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 4,
  parameter int COL_NUM    = 4,
  parameter int LENGTH     = 4,
  parameter int KT_W       = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [KT_W-1:0]                         k_tiles,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0]    mat,
  input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]    fil,
  output logic [OUT_WIDTH*ROW_NUM*COL_NUM-1:0]    res,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    busy
);

  localparam int N  = ROW_NUM * COL_NUM;
  localparam int MW = 2 * DATA_WIDTH;
  localparam int PW = MW + $clog2(LENGTH);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                       state;
  logic [KT_W-1:0]              cnt;
  logic [KT_W-1:0]              kt;
  logic                         p_v;
  logic signed [ACC_WIDTH-1:0]  p_d [N];
  logic signed [ACC_WIDTH-1:0]  p_q [N];
  logic signed [ACC_WIDTH-1:0]  acc [N];
  logic                         take;

  assign take = in_valid && in_ready;

  function automatic logic [OUT_WIDTH-1:0] sat(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic signed [ACC_WIDTH-1:0] sh;
    sh = v >>> SHIFT;
    if (sh > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
    else if (sh < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    else                   return sh[OUT_WIDTH-1:0];
  endfunction

  // Full-precision dot product, sign-extended into the accumulator width.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [MW-1:0]         m;
    logic signed [PW-1:0]         s;
    a = '0;
    b = '0;
    m = '0;
    s = '0;
    for (int n = 0; n < N; n++) p_d[n] = '0;
    for (int i = 0; i < ROW_NUM; i++) begin
      for (int j = 0; j < COL_NUM; j++) begin
        s = '0;
        for (int k = 0; k < LENGTH; k++) begin
          a = mat[(i*LENGTH+k)*DATA_WIDTH +: DATA_WIDTH];
          b = fil[(k*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH];
          m = a * b;
          s = s + PW'(m);
        end
        p_d[i*COL_NUM+j] = ACC_WIDTH'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
      cnt       <= '0;
      kt        <= '0;
      p_v       <= 1'b0;
      for (int n = 0; n < N; n++) begin
        p_q[n] <= '0;
        acc[n] <= '0;
      end
    end else begin
      p_v <= take;
      if (take)
        for (int n = 0; n < N; n++) p_q[n] <= p_d[n];
      if (p_v)
        for (int n = 0; n < N; n++) acc[n] <= acc[n] + p_q[n];
      unique case (state)
        IDLE: begin
          if (start) begin
            kt   <= k_tiles;
            cnt  <= '0;
            busy <= 1'b1;
            for (int n = 0; n < N; n++) acc[n] <= '0;
            if (k_tiles == '0) begin
              state <= DRAIN;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (take) begin
            cnt <= cnt + KT_W'(1);
            if ((cnt + KT_W'(1)) == kt) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last product lands in acc on the edge where p_v is still set.
          if (!p_v) begin
            for (int n = 0; n < N; n++)
              res[n*OUT_WIDTH +: OUT_WIDTH] <= sat(acc[n]);
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_stream_acc.sv
// Directed bench for mm_stream_acc: a table of jobs plus hand sequences
// for backpressure, ignored start, reset mid-job and k_tiles=0.
module tb_mm_stream_acc;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, out_ready;
  logic [7:0]   k_tiles;
  logic [127:0] mat, fil;
  logic [255:0] res, res_s;
  logic         in_ready, out_valid, busy;
  logic         in_ready_s, out_valid_s, busy_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mm_stream_acc u_dut (
    .clk(clk), .reset(reset), .start(start), .k_tiles(k_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .mat(mat), .fil(fil),
    .res(res), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  mm_stream_acc #(.SHIFT(4)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .k_tiles(k_tiles),
    .in_valid(in_valid), .in_ready(in_ready_s), .mat(mat), .fil(fil),
    .res(res_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .busy(busy_s)
  );

  typedef struct {
    string        name;
    logic [7:0]   kt;
    logic [127:0] mat;
    logic [127:0] fil;
    bit           bubble;
    logic [255:0] exp;
    logic [255:0] exp_s;
  } vec_t;

  vec_t vecs[7];
  vec_t vr;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fill8(input int v);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[n*8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [255:0] fill16(input int v);
    logic [255:0] r;
    for (int n = 0; n < 16; n++) r[n*16 +: 16] = v[15:0];
    return r;
  endfunction

  task automatic drive_to_out(input vec_t v, output int lat);
    int  got;
    int  guard;
    bit  gap;
    bit  vld;
    bit  acc;
    got   = 0;
    guard = 0;
    gap   = 0;
    start   = 1'b1;
    k_tiles = v.kt;
    mat     = v.mat;
    fil     = v.fil;
    step();
    start = 1'b0;
    while (got < int'(v.kt) && guard < 100) begin
      vld = !(v.bubble && got > 0 && !gap);
      in_valid = vld;
      acc = vld && in_ready;
      step();
      guard++;
      if (acc) begin
        got++;
        gap = 0;
      end else if (!vld) begin
        gap = 1;
      end
    end
    in_valid = 1'b0;
    chk({v.name, "_beats"}, 256'(got), 256'(v.kt));
    if (v.kt != 0)
      chk({v.name, "_in_ready_low"}, {255'b0, in_ready}, 256'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_job(input vec_t v);
    int lat;
    drive_to_out(v, lat);
    chk({v.name, "_latency"}, 256'(lat), (v.kt == 0) ? 256'd1 : 256'd2);
    chk({v.name, "_busy"}, {255'b0, busy}, 256'd1);
    chk({v.name, "_res"}, res, v.exp);
    chk({v.name, "_valid_s"}, {255'b0, out_valid_s}, 256'd1);
    chk({v.name, "_res_s"}, res_s, v.exp_s);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, "_valid_drop"}, {255'b0, out_valid}, 256'd0);
    chk({v.name, "_busy_drop"}, {254'b0, busy, busy_s}, 256'd0);
  endtask

  initial begin
    logic [127:0] m;
    logic [127:0] f;
    logic [255:0] e;
    logic [255:0] es;

    m = '0; f = '0; e = '0; es = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m[(i*4+j)*8 +: 8]  = (i == j) ? 8'd1 : 8'd0;
        f[(i*4+j)*8 +: 8]  = 8'(i*4 + j + 1);
        e[(i*4+j)*16 +: 16] = 16'(i*4 + j + 1);
        es[(i*4+j)*16 +: 16] = 16'((i*4 + j + 1) >> 4);
      end
    vecs[0] = '{"identity", 8'd1, m, f, 1'b0, e, es};
    vecs[1] = '{"accum3", 8'd3, fill8(1), fill8(2), 1'b1,
                fill16(24), fill16(1)};
    vecs[2] = '{"sat_pos", 8'd2, fill8(-128), fill8(-128), 1'b0,
                fill16(32767), fill16(8192)};
    vecs[3] = '{"sat_neg", 8'd2, fill8(-128), fill8(127), 1'b0,
                fill16(-32768), fill16(-8128)};
    vecs[4] = '{"small_pos", 8'd1, fill8(1), fill8(3), 1'b0,
                fill16(12), fill16(0)};
    vecs[5] = '{"small_neg", 8'd1, fill8(1), fill8(-3), 1'b0,
                fill16(-12), fill16(-1)};
    vecs[6] = '{"ktiles0", 8'd0, fill8(7), fill8(7), 1'b0,
                fill16(0), fill16(0)};

    f = '0;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      f[(i*4+i)*8 +: 8]   = 8'd5;
      e[(i*4+i)*16 +: 16] = 16'd5;
    end
    vr = '{"after_reset", 8'd1, m, f, 1'b0, e, 256'd0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_tiles = '0; mat = '0; fil = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_flags", {253'b0, in_ready, out_valid, busy}, 256'd0);
    chk("reset_res", res, 256'd0);

    for (int t = 0; t < 7; t++) run_job(vecs[t]);

    // Held output under backpressure with stray start pulses.
    begin
      int lat;
      drive_to_out(vecs[4], lat);
      for (int c = 0; c < 10; c++) begin
        start   = (c % 3 == 0);
        k_tiles = 8'd5;
        out_ready = 1'b0;
        step();
        chk("hold_res", res, vecs[4].exp);
        chk("hold_valid", {255'b0, out_valid}, 256'd1);
      end
      start = 1'b1;
      out_ready = 1'b1;
      step();
      start = 1'b0;
      out_ready = 1'b0;
      chk("hold_release", {254'b0, out_valid, busy}, 256'd0);
      step();
      chk("no_new_job", {254'b0, busy, in_ready}, 256'd0);
    end

    // Reset mid-ACCUM after two of four beats.
    start = 1'b1; k_tiles = 8'd4; mat = fill8(1); fil = fill8(1);
    step();
    start = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    chk("mid_in_ready", {255'b0, in_ready}, 256'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("mid_reset_flags", {253'b0, in_ready, out_valid, busy}, 256'd0);
    chk("mid_reset_res", res, 256'd0);
    run_job(vr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
